// File: rtl/clk_wiz_pkg.sv
// clk_wiz_seq shared types and defaults.
// State encoding, timing defaults, timer sizing.
package clk_wiz_pkg;

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        RESET     = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int unsigned DEF_SETTLE_CYC       = 1024;
    localparam int unsigned DEF_MAX_RETRIES      = 3;

    // Bits needed to hold the longest interval count.
    function automatic int unsigned tmr_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous status.
// Width and reset value are parameters.
module sync_2ff #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] s1;
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] s2;

    // Metastability chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/clk_wiz_seq.sv
// Power-up / recovery sequencer for the clk_wiz_0 network.
// Runs on the free-running board clock.
module clk_wiz_seq
    import clk_wiz_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned SETTLE_CYC       = DEF_SETTLE_CYC,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int unsigned TMR_W            =
        tmr_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, SETTLE_CYC)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       input_clk_stopped,
    input  logic       pd_req,
    input  logic       restart_req,
    output logic       mmcm_reset,
    output logic       mmcm_power_down,
    output logic       rst_out,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] SET_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    logic [1:0]       sync_q;
    logic             locked_s;
    logic             stop_s;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [3:0]       retry_d;
    logic [7:0]       loss_d;

    logic             mr_d;
    logic             pd_d;
    logic             ro_d;
    logic             rdy_d;
    logic             fail_d;

    sync_2ff #(
        .W       (2),
        .RST_VAL (2'b00)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({input_clk_stopped, locked}),
        .q       (sync_q)
    );

    assign locked_s = sync_q[0];
    assign stop_s   = sync_q[1];
    assign state    = state_q;

    // Next state, timer and counters; pd_req beats restart_req.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        retry_d = retry_cnt;
        loss_d  = lock_loss_cnt;
        if (pd_req) begin
            state_d = PWRDN;
        end else if (restart_req && state_q != PWRDN) begin
            state_d = RESET;
            tmr_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PWRDN: begin
                    state_d = RESET;
                    retry_d = '0;
                end
                RESET: begin
                    if (tmr_q == RST_LAST) state_d = WAIT_LOCK;
                    else tmr_d = tmr_q + 1'b1;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = SETTLE;
                    end else if (tmr_q == LOCK_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = RESET;
                            retry_d = retry_cnt + 4'd1;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = RESET;
                            retry_d = retry_cnt + 4'd1;
                        end
                    end else if (tmr_q == SET_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s || stop_s) begin
                        state_d = RESET;
                        if (lock_loss_cnt != 8'hFF)
                            loss_d = lock_loss_cnt + 8'd1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET;
                end
            endcase
        end
        if (state_d != state_q) tmr_d = '0;
    end

    // Output decode from the next state so outputs move with the state.
    always_comb begin
        mr_d   = 1'b1;
        pd_d   = 1'b0;
        ro_d   = 1'b1;
        rdy_d  = 1'b0;
        fail_d = 1'b0;
        unique case (1'b1)
            (state_d == PWRDN): pd_d = 1'b1;
            (state_d == WAIT_LOCK),
            (state_d == SETTLE): mr_d = 1'b0;
            (state_d == RUN): begin
                mr_d  = 1'b0;
                ro_d  = 1'b0;
                rdy_d = 1'b1;
            end
            (state_d == FAIL): fail_d = 1'b1;
            default: ;
        endcase
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RESET;
            tmr_q           <= '0;
            retry_cnt       <= '0;
            lock_loss_cnt   <= '0;
            mmcm_reset      <= 1'b1;
            mmcm_power_down <= 1'b0;
            rst_out         <= 1'b1;
            ready           <= 1'b0;
            fail            <= 1'b0;
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            retry_cnt       <= retry_d;
            lock_loss_cnt   <= loss_d;
            mmcm_reset      <= mr_d;
            mmcm_power_down <= pd_d;
            rst_out         <= ro_d;
            ready           <= rdy_d;
            fail            <= fail_d;
        end
    end

endmodule

// File: tb/tb_clk_wiz_seq.sv
// Randomised bench for clk_wiz_seq.
// Cycle-accurate reference model compared every edge.
module tb_clk_wiz_seq;
    import clk_wiz_pkg::*;

    localparam int unsigned P_RST = 4;
    localparam int unsigned P_TO  = 32;
    localparam int unsigned P_SET = 8;
    localparam int unsigned P_MAX = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       locked;
    logic       input_clk_stopped;
    logic       pd_req;
    logic       restart_req;
    logic       mmcm_reset;
    logic       mmcm_power_down;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    state_t m_st;
    int     m_cyc;
    int     m_retry;
    int     m_loss;
    logic   m_l1, m_l2, m_s1, m_s2;

    clk_wiz_seq #(
        .RST_PULSE_CYC    (P_RST),
        .LOCK_TIMEOUT_CYC (P_TO),
        .SETTLE_CYC       (P_SET),
        .MAX_RETRIES      (P_MAX)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .locked            (locked),
        .input_clk_stopped (input_clk_stopped),
        .pd_req            (pd_req),
        .restart_req       (restart_req),
        .mmcm_reset        (mmcm_reset),
        .mmcm_power_down   (mmcm_power_down),
        .rst_out           (rst_out),
        .ready             (ready),
        .fail              (fail),
        .retry_cnt         (retry_cnt),
        .lock_loss_cnt     (lock_loss_cnt),
        .state             (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_vec();
        return {state, mmcm_reset, mmcm_power_down, rst_out, ready,
                fail, retry_cnt, lock_loss_cnt};
    endfunction

    function automatic logic [19:0] exp_vec();
        logic mr, pd, ro, rd, fl;
        mr = (m_st == PWRDN) || (m_st == RESET) || (m_st == FAIL);
        pd = (m_st == PWRDN);
        ro = (m_st != RUN);
        rd = (m_st == RUN);
        fl = (m_st == FAIL);
        return {m_st, mr, pd, ro, rd, fl, 4'(m_retry), 8'(m_loss)};
    endfunction

    task automatic m_reset();
        m_st    = RESET;
        m_cyc   = 0;
        m_retry = 0;
        m_loss  = 0;
        m_l1 = 1'b0; m_l2 = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic m_go(input state_t s);
        m_st  = s;
        m_cyc = 0;
    endtask

    task automatic m_attempt_failed();
        if (m_retry == P_MAX) m_go(FAIL);
        else begin
            m_retry++;
            m_go(RESET);
        end
    endtask

    // One clock edge of the behavioural sequence.
    task automatic m_step();
        logic ls, ss;
        ls = m_l2;
        ss = m_s2;
        m_l2 = m_l1; m_s2 = m_s1;
        m_l1 = locked; m_s1 = input_clk_stopped;
        if (pd_req) m_go(PWRDN);
        else if (restart_req && m_st != PWRDN) begin
            m_go(RESET);
            m_retry = 0;
        end else begin
            case (m_st)
                PWRDN: begin m_go(RESET); m_retry = 0; end
                RESET: begin
                    m_cyc++;
                    if (m_cyc == P_RST) m_go(WAIT_LOCK);
                end
                WAIT_LOCK: begin
                    if (ls) m_go(SETTLE);
                    else begin
                        m_cyc++;
                        if (m_cyc == P_TO) m_attempt_failed();
                    end
                end
                SETTLE: begin
                    if (!ls) m_attempt_failed();
                    else begin
                        m_cyc++;
                        if (m_cyc == P_SET) begin
                            m_go(RUN);
                            m_retry = 0;
                        end
                    end
                end
                RUN: begin
                    if (!ls || ss) begin
                        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                        m_go(RESET);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check("cycle", dut_vec(), exp_vec());
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && !ready; i++) tick();
        check(tag, ready, 1);
    endtask

    task automatic wait_state(input string tag, input state_t s,
                              input int budget);
        for (int i = 0; i < budget && state != s; i++) tick();
        check(tag, state, s);
    endtask

    int n;

    initial begin
        reset_n = 1'b0;
        locked = 1'b0;
        input_clk_stopped = 1'b0;
        pd_req = 1'b0;
        restart_req = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_vec", dut_vec(), exp_vec());
        check("reset_rst_out", rst_out, 1);
        reset_n = 1'b1;

        // Cold start with a late lock.
        n = 0;
        while (mmcm_reset && n < 20) begin tick(); n++; end
        check("s1_mr_width", n, P_RST);
        repeat (9) tick();
        locked = 1'b1;
        n = 0;
        while (rst_out && n < 40) begin tick(); n++; end
        check("s1_latency", n, 2 + 1 + P_SET);
        check("s1_ready", ready, 1);
        check("s1_retry", retry_cnt, 0);

        // Lock never arrives: retries then FAIL.
        locked = 1'b0;
        pulse_restart();
        for (int k = 0; k < 3; k++) begin
            check("s2_retry", retry_cnt, k);
            n = 0;
            while (mmcm_reset && n < 50) begin tick(); n++; end
            check("s2_pulse", n, P_RST);
            n = 0;
            while (!mmcm_reset && n < 50) begin tick(); n++; end
            check("s2_wait", n, P_TO);
        end
        check("s2_fail", fail, 1);
        check("s2_retry_max", retry_cnt, P_MAX);
        repeat (5) tick();
        check("s2_fail_hold", {fail, mmcm_reset}, 2'b11);
        pulse_restart();
        check("s2_restart", state, RESET);
        check("s2_retry_clr", retry_cnt, 0);

        // Lock loss in RUN.
        locked = 1'b1;
        wait_ready("s3_run", 80);
        repeat (2) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        n = 0;
        while (!rst_out && n < 10) begin tick(); n++; end
        check("s3_drop_lat", n, 2);
        check("s3_loss", lock_loss_cnt, 1);
        wait_ready("s3_rerun", 80);

        // Lock loss during SETTLE.
        pulse_restart();
        wait_state("s4_settle", SETTLE, 40);
        repeat (3) tick();
        locked = 1'b0;
        n = 0;
        while (state != RESET && n < 10) begin
            tick();
            check("s4_rst_out", rst_out, 1);
            n++;
        end
        check("s4_retry", retry_cnt, 1);
        locked = 1'b1;
        wait_ready("s4_rerun", 80);

        // Power-down from RUN and from WAIT_LOCK.
        pd_req = 1'b1;
        tick();
        check("s5_pd_run", {mmcm_power_down, rst_out}, 2'b11);
        pulse_restart();
        check("s5_restart_ign", state, PWRDN);
        tick();
        pd_req = 1'b0;
        tick();
        check("s5_exit", state, RESET);
        wait_ready("s5_rerun", 80);
        locked = 1'b0;
        pulse_restart();
        wait_state("s5_wait", WAIT_LOCK, 20);
        pd_req = 1'b1;
        tick();
        check("s5_pd_wait", {mmcm_power_down, rst_out}, 2'b11);
        pd_req = 1'b0;
        locked = 1'b1;
        wait_ready("s5_rerun2", 80);

        // Async reset mid-SETTLE, then saturate the loss counter.
        pulse_restart();
        wait_state("s6_settle", SETTLE, 40);
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1 m_reset();
        check("s6_async", dut_vec(), exp_vec());
        check("s6_loss_clr", lock_loss_cnt, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wait_ready("s6_run", 60);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom % 2 == 0) locked = 1'b0;
            else input_clk_stopped = 1'b1;
            tick();
            locked = 1'b1;
            input_clk_stopped = 1'b0;
            repeat (3) tick();
        end
        check("s6_saturate", lock_loss_cnt, 255);

        // Free-running random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (locked) locked = ($urandom % 40) != 0;
            else locked = ($urandom % 6) == 0;
            input_clk_stopped = ($urandom % 150) == 0;
            if ($urandom % 200 == 0) pd_req = ~pd_req;
            restart_req = ($urandom % 250) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_wiz_seq.md
Name: clk_wiz_seq

Overview:
- Power-up and recovery sequencer for the clk_wiz_0 clocking network.
- Drives the network's reset and power_down inputs and watches locked and input_clk_stopped.
- Retries lock with a bounded timeout, then releases an active-high downstream reset (the reset_int/COUNTER_RESET role) only after a settling interval.
- Runs on a free-running board clock, never on an MMCM output.

Parameters:
- RST_PULSE_CYC, 16: cycles mmcm_reset is held high per attempt (>=1).
- LOCK_TIMEOUT_CYC, 65536: cycles allowed in WAIT_LOCK before an attempt fails.
- SETTLE_CYC, 1024: cycles locked must stay high before rst_out releases.
- MAX_RETRIES, 3: failed attempts tolerated before FAIL (retry_cnt width 4).
- TMR_W, 17: timer width; must hold max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, SETTLE_CYC).

Ports:
- clk  input  1  free-running sequencer clock.
- reset_n  input  1  asynchronous active-low reset.
- locked  input  1  clk_wiz_0 locked; asynchronous, synchronised internally.
- input_clk_stopped  input  1  clk_wiz_0 status; asynchronous, synchronised internally.
- pd_req  input  1  level; power the MMCM down while high.
- restart_req  input  1  single-cycle pulse; restart the sequence and clear retry_cnt.
- mmcm_reset  output  1  to clk_wiz_0 reset.
- mmcm_power_down  output  1  to clk_wiz_0 power_down.
- rst_out  output  1  active-high downstream reset.
- ready  output  1  high only in RUN.
- fail  output  1  high only in FAIL.
- retry_cnt  output  4  failed attempts in the current sequence.
- lock_loss_cnt  output  8  saturating count of RUN→RESET drops.
- state  output  3  encoded current state, for debug.

Behaviour:
- Reset behaviour (reset_n low):
  - state=RESET, timer=0.
  - mmcm_reset=1, mmcm_power_down=0, rst_out=1, ready=0, fail=0.
  - retry_cnt=0, lock_loss_cnt=0.
- Synchronisers:
  - locked and input_clk_stopped each pass through a 2-flop synchroniser (ASYNC_REG), giving locked_s and stop_s.
  - The synchronisers reset to 0.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Priority each cycle:
  1. pd_req
  2. restart_req
  3. per-state rules
- PWRDN (0):
  - Outputs: mmcm_power_down=1, mmcm_reset=1, rst_out=1.
  - When pd_req is low: go to RESET, timer=0, retry_cnt=0.
  - restart_req is ignored here.
- restart_req in any state other than PWRDN: go to RESET, timer=0, retry_cnt=0.
- RESET (1):
  - Outputs: mmcm_reset=1, rst_out=1.
  - The timer counts cycles. After exactly RST_PULSE_CYC cycles in RESET, go to WAIT_LOCK with timer=0.
- WAIT_LOCK (2):
  - Outputs: mmcm_reset=0, rst_out=1.
  - If locked_s=1: go to SETTLE, timer=0.
  - Otherwise, if timer reaches LOCK_TIMEOUT_CYC-1:
    - retry_cnt==MAX_RETRIES → FAIL.
    - Otherwise retry_cnt+1 → RESET.
  - stop_s only keeps the attempt in WAIT_LOCK until the timeout fires.
- SETTLE (3):
  - Outputs: rst_out=1.
  - If locked_s=0: retry_cnt+1 → RESET; when retry_cnt==MAX_RETRIES → FAIL instead.
  - If SETTLE_CYC consecutive cycles pass with locked_s=1: go to RUN, rst_out=0, ready=1, retry_cnt=0.
- RUN (4):
  - Outputs: rst_out=0, ready=1.
  - If locked_s=0 or stop_s=1: go to RESET on the next edge, rst_out=1, ready=0, lock_loss_cnt+1 (saturates at 255).
- FAIL (5):
  - Outputs: fail=1, mmcm_reset=1, rst_out=1.
  - Exit only via restart_req or pd_req.
- Latency:
  - An asynchronous locked rise is seen in the state register 3 clk edges later at most.
  - From locked_s=1 in WAIT_LOCK to rst_out=0 takes SETTLE_CYC+1 edges.
- Timer:
  - Clears on every state change.
  - Never wraps: TMR_W is sized per the parameter rule.
- Unused state encodings go to RESET.

Decomposition:
- Shared package clk_wiz_pkg holds:
  - the state enum (PWRDN=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAIL=5);
  - the default timing constants;
  - a function returning the timer width from the parameters.
- One sub-module: sync_2ff (parameterised width and reset value). It is instantiated once with width 2 for locked and input_clk_stopped.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, SETTLE_CYC=8, MAX_RETRIES=2.
1. reset_n released; locked rises 10 cycles after mmcm_reset falls → mmcm_reset high exactly 4 cycles; rst_out falls 8+1 edges after locked_s=1; ready=1, retry_cnt=0.
2. locked held 0 → three RESET pulses of 4 cycles spaced 32 WAIT_LOCK cycles; retry_cnt goes 0,1,2; then fail=1 with mmcm_reset=1; a restart_req pulse returns to RESET with retry_cnt=0.
3. In RUN, drop locked for 1 cycle → rst_out=1 within 3 edges; lock_loss_cnt=1; full resequence back to RUN.
4. In SETTLE, drop locked at cycle 5 → RESET, retry_cnt=1, rst_out stays 1 throughout.
5. pd_req asserted in RUN and also in WAIT_LOCK → mmcm_power_down=1, rst_out=1 next edge; a restart_req pulse while pd_req=1 has no effect; deassert pd_req → RESET and the normal sequence follows.
6. reset_n pulsed low mid-SETTLE → all outputs return to reset values asynchronously and both counters clear; force 300 RUN lock losses → lock_loss_cnt saturates at 255.
